// File: rtl/gpr_scoreboard.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard
//
// Tracks outstanding GPR writes between decode/issue and write-back. Each
// register owns a small saturating-free pending-write counter; decode uses the
// dirty flags to detect RAW hazards on its source operands and issue_ready_o to
// avoid overflowing a destination counter.
//
// Ports
//   clk_i          system clock, all state updates on the rising edge
//   rstn_i         asynchronous active-low reset
//   issue_valid_i  decode presents an instruction this cycle
//   issue_wr_i     presented instruction writes a GPR
//   issue_rd_i     destination index of the presented instruction
//   issue_ready_o  destination counter has room for one more pending write
//   wb_valid_i     write-back retires a GPR write this cycle
//   wb_rd_i        destination index being retired
//   flush_i        discard all pending writes
//   rs1_i, rs2_i   source indices queried by decode
//   rs1_dirty_o,
//   rs2_dirty_o    queried register has a pending write (registered state only)
//   busy_o         at least one register has a pending write
//   error_o        sticky: a retire targeted a register with no pending write
// -----------------------------------------------------------------------------
module gpr_scoreboard #(
    parameter int unsigned NB_REGS       = 32,
    parameter int unsigned CNT_WIDTH     = 2,
    parameter int unsigned RF_ADDR_WIDTH = 5
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     issue_valid_i,
    input  logic                     issue_wr_i,
    input  logic [RF_ADDR_WIDTH-1:0] issue_rd_i,
    output logic                     issue_ready_o,
    input  logic                     wb_valid_i,
    input  logic [RF_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic                     flush_i,
    input  logic [RF_ADDR_WIDTH-1:0] rs1_i,
    input  logic [RF_ADDR_WIDTH-1:0] rs2_i,
    output logic                     rs1_dirty_o,
    output logic                     rs2_dirty_o,
    output logic                     busy_o,
    output logic                     error_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q [NB_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NB_REGS];
    logic                 err_q;
    logic                 err_d;

    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [CNT_WIDTH-1:0] rs1_cnt;
    logic [CNT_WIDTH-1:0] rs2_cnt;
    logic                 any_pending;
    logic                 issue_acc;
    logic                 retire;

    // Index lookups are done by comparison rather than array indexing so that
    // indices >= NB_REGS simply match nothing and read back as zero.
    always_comb begin
        rd_cnt      = '0;
        rs1_cnt     = '0;
        rs2_cnt     = '0;
        any_pending = 1'b0;
        for (int i = 0; i < NB_REGS; i++) begin
            if (RF_ADDR_WIDTH'(i) == issue_rd_i) rd_cnt  = cnt_q[i];
            if (RF_ADDR_WIDTH'(i) == rs1_i)      rs1_cnt = cnt_q[i];
            if (RF_ADDR_WIDTH'(i) == rs2_i)      rs2_cnt = cnt_q[i];
            if (cnt_q[i] != '0)                  any_pending = 1'b1;
        end
    end

    // Ready deliberately ignores issue_valid_i so decode can evaluate it early.
    assign issue_ready_o = !(issue_wr_i && (issue_rd_i != '0) && (rd_cnt == CNT_MAX));
    assign issue_acc     = issue_valid_i && issue_wr_i && issue_ready_o &&
                           !flush_i && (issue_rd_i != '0);
    assign retire        = wb_valid_i && (wb_rd_i != '0) && !flush_i;

    assign rs1_dirty_o = (rs1_cnt != '0);
    assign rs2_dirty_o = (rs2_cnt != '0);
    assign busy_o      = any_pending;
    assign error_o     = err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (flush_i) begin
            for (int i = 0; i < NB_REGS; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            // x0 is skipped: its counter never moves.
            for (int i = 1; i < NB_REGS; i++) begin
                if (retire && (RF_ADDR_WIDTH'(i) == wb_rd_i) && (cnt_q[i] == '0)) begin
                    err_d = 1'b1;
                end
                // Issue and retire to the same register cancel out.
                if (issue_acc && (RF_ADDR_WIDTH'(i) == issue_rd_i) &&
                    !(retire && (RF_ADDR_WIDTH'(i) == wb_rd_i))) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end else if (retire && (RF_ADDR_WIDTH'(i) == wb_rd_i) &&
                             !(issue_acc && (RF_ADDR_WIDTH'(i) == issue_rd_i)) &&
                             (cnt_q[i] != '0)) begin
                    cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NB_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_gpr_scoreboard.sv
module tb_gpr_scoreboard;

    localparam int NB   = 32;
    localparam int CW   = 2;
    localparam int AW   = 5;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          issue_valid, issue_wr, wb_valid, flush;
    logic [AW-1:0] issue_rd, wb_rd, rs1, rs2;
    logic          issue_ready, rs1_dirty, rs2_dirty, busy, error;

    int tests = 0;
    int fails = 0;

    // Reference model: pending-write count per register, plus sticky error.
    int mcnt [NB];
    bit merr;

    always #5 clk = ~clk;

    gpr_scoreboard #(
        .NB_REGS      (NB),
        .CNT_WIDTH    (CW),
        .RF_ADDR_WIDTH(AW)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .issue_valid_i(issue_valid),
        .issue_wr_i   (issue_wr),
        .issue_rd_i   (issue_rd),
        .issue_ready_o(issue_ready),
        .wb_valid_i   (wb_valid),
        .wb_rd_i      (wb_rd),
        .flush_i      (flush),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .rs1_dirty_o  (rs1_dirty),
        .rs2_dirty_o  (rs2_dirty),
        .busy_o       (busy),
        .error_o      (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        int r = int'(issue_rd);
        return !(issue_wr && r != 0 && r < NB && mcnt[r] == CMAX);
    endfunction

    function automatic bit m_dirty(input int idx);
        return (idx < NB) && (mcnt[idx] != 0);
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < NB; i++) if (mcnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NB; i++) mcnt[i] = 0;
        merr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/ready"}, issue_ready, m_ready());
        check({tag, "/rs1"},   rs1_dirty,   m_dirty(int'(rs1)));
        check({tag, "/rs2"},   rs2_dirty,   m_dirty(int'(rs2)));
        check({tag, "/busy"},  busy,        m_busy());
        check({tag, "/err"},   error,       merr);
    endtask

    task automatic drive(input bit iv, input bit iw, input int ird,
                         input bit wv, input int wrd, input bit fl,
                         input int r1, input int r2);
        issue_valid = iv;
        issue_wr    = iw;
        issue_rd    = AW'(ird);
        wb_valid    = wv;
        wb_rd       = AW'(wrd);
        flush       = fl;
        rs1         = AW'(r1);
        rs2         = AW'(r2);
    endtask

    // Check outputs against the model, then advance DUT and model one clock.
    task automatic step(input string tag);
        int  nxt [NB];
        bit  nerr;
        int  ird, wrd;
        bit  acc, ret;
        #1;
        check_all(tag);
        nxt  = mcnt;
        nerr = merr;
        ird  = int'(issue_rd);
        wrd  = int'(wb_rd);
        acc  = issue_valid && issue_wr && m_ready() && !flush && ird != 0 && ird < NB;
        ret  = wb_valid && !flush && wrd != 0 && wrd < NB;
        if (flush) begin
            for (int i = 0; i < NB; i++) nxt[i] = 0;
        end else if (acc && ret && ird == wrd) begin
            if (mcnt[wrd] == 0) nerr = 1'b1;
        end else begin
            if (acc) nxt[ird] = mcnt[ird] + 1;
            if (ret) begin
                if (mcnt[wrd] > 0) nxt[wrd] = mcnt[wrd] - 1;
                else               nerr = 1'b1;
            end
        end
        @(posedge clk);
        mcnt = nxt;
        merr = nerr;
        @(negedge clk);
    endtask

    initial begin
        m_reset();
        rstn = 1'b0;
        drive(0, 1, 5, 0, 0, 0, 5, 7);
        #3;
        check("rst/ready", issue_ready, 1'b1);
        check("rst/rs1",   rs1_dirty,   1'b0);
        check("rst/busy",  busy,        1'b0);
        check("rst/err",   error,       1'b0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Single issue then retire on x5.
        drive(1, 1, 5, 0, 0, 0, 5, 0);  step("r32_issue");
        drive(0, 0, 0, 0, 0, 0, 5, 0);  #1;
        check("r32_dirty", rs1_dirty, 1'b1);
        check("r32_busy",  busy,      1'b1);
        step("r32_idle");
        drive(0, 0, 0, 1, 5, 0, 5, 0);  step("r32_retire");
        drive(0, 0, 0, 0, 0, 0, 5, 0);  #1;
        check("r32_clean", rs1_dirty, 1'b0);
        check("r32_nobusy", busy,     1'b0);
        step("r32_idle2");

        // Fill x7 to maximum.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 7, 0, 0, 0, 7, 8);  step("r33_fill");
        end
        drive(0, 1, 7, 0, 0, 0, 7, 8);  #1;
        check("r33_full7", issue_ready, 1'b0);
        step("r33_q7");
        drive(1, 1, 8, 0, 0, 0, 7, 8);  #1;
        check("r33_ok8", issue_ready, 1'b1);
        step("r33_i8");
        drive(0, 1, 7, 1, 7, 0, 7, 8);  step("r33_ret7");
        drive(0, 1, 7, 0, 0, 0, 7, 8);  #1;
        check("r33_again7", issue_ready, 1'b1);
        step("r33_q7b");
        drive(0, 0, 0, 1, 7, 0, 7, 8);  step("r33_drain7a");
        drive(0, 0, 0, 1, 7, 0, 7, 8);  step("r33_drain7b");
        drive(0, 0, 0, 1, 8, 0, 7, 8);  step("r33_drain8");

        // Concurrent issue and retire to the same register.
        drive(1, 1, 3, 0, 0, 0, 0, 3);  step("r34_issue");
        drive(1, 1, 3, 1, 3, 0, 0, 3);  step("r34_both");
        drive(0, 0, 0, 0, 0, 0, 0, 3);  #1;
        check("r34_dirty", rs2_dirty, 1'b1);
        step("r34_idle");
        drive(0, 0, 0, 1, 3, 0, 0, 3);  step("r34_drain");

        // x0 traffic is inert; retire of an idle register raises error.
        drive(1, 1, 0, 1, 0, 0, 0, 0);  step("r35_x0");
        drive(0, 0, 0, 0, 0, 0, 0, 0);  #1;
        check("r35_busy", busy,  1'b0);
        check("r35_err0", error, 1'b0);
        step("r35_idle");
        drive(0, 0, 0, 1, 9, 0, 9, 0);  step("r35_ret9");
        drive(0, 0, 0, 0, 0, 0, 9, 0);  #1;
        check("r35_err1", error, 1'b1);
        step("r35_hold1");
        step("r35_hold2");
        check("r35_sticky", error, 1'b1);

        // Flush overrides a concurrent issue.
        drive(1, 1, 1, 0, 0, 0, 1, 31);  step("r36_i1");
        drive(1, 1, 2, 0, 0, 0, 2, 31);  step("r36_i2");
        drive(1, 1, 31, 0, 0, 0, 1, 31); step("r36_i31");
        drive(1, 1, 4, 0, 0, 1, 4, 31);  step("r36_flush");
        drive(0, 0, 0, 0, 0, 0, 4, 31);  #1;
        check("r36_busy", busy,      1'b0);
        check("r36_rs1",  rs1_dirty, 1'b0);
        check("r36_rs2",  rs2_dirty, 1'b0);
        step("r36_idle");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit iv, iw, wv, fl;
            int ird, wrd;
            iv  = ($urandom_range(0, 3) != 0);
            iw  = ($urandom_range(0, 4) != 0);
            ird = $urandom_range(0, 6);
            wv  = ($urandom_range(0, 2) == 0);
            wrd = $urandom_range(0, 6);
            fl  = ($urandom_range(0, 29) == 0);
            drive(iv, iw, ird, wv, wrd, fl, $urandom_range(0, 31), $urandom_range(0, 7));
            // Keep clear of the same-register issue/retire on an idle counter.
            if (iv && iw && ird != 0 && ird == wrd && mcnt[ird] == 0) wb_valid = 1'b0;
            step("rand");
        end

        // Asynchronous reset between edges with writes pending.
        drive(1, 1, 6, 0, 0, 0, 6, 0);  step("r37_i6a");
        drive(1, 1, 6, 0, 0, 0, 6, 0);  step("r37_i6b");
        drive(0, 0, 0, 1, 9, 0, 9, 0);  step("r37_err");
        drive(0, 1, 6, 0, 0, 0, 6, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("r37_ready", issue_ready, 1'b1);
        check("r37_rs1",   rs1_dirty,   1'b0);
        check("r37_busy",  busy,        1'b0);
        check("r37_err",   error,       1'b0);
        m_reset();
        drive(0, 0, 0, 0, 0, 0, 6, 0);
        rstn = 1'b1;
        step("r37_post");
        drive(1, 1, 6, 0, 0, 0, 6, 0);  step("r37_fresh");
        drive(0, 0, 0, 1, 6, 0, 6, 0);  step("r37_ret");
        drive(0, 0, 0, 0, 0, 0, 6, 0);  step("r37_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
